// File: rtl/ula_seq_pkg.sv
// Shared types and constants for the multi-byte ULA sequencer.
package ula_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  localparam int unsigned SLICE_W = 8;

  localparam logic [3:0] SEL_ADD = 4'b0101;
  localparam logic [3:0] SEL_SUB = 4'b1000;

endpackage

// File: rtl/ula_seq_multibyte.sv
// Feeds a wide operation through an 8-bit ULA one slice per cycle, LSB first,
// chaining carry between slices, and returns the assembled result.
module ula_seq_multibyte
  import ula_seq_pkg::*;
#(
  parameter int unsigned N_BYTES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [SLICE_W*N_BYTES-1:0] req_a,
  input  logic [SLICE_W*N_BYTES-1:0] req_b,
  input  logic [3:0]                 req_s,
  input  logic                       req_m,
  input  logic                       req_c_in,
  output logic [SLICE_W-1:0]         ula_a,
  output logic [SLICE_W-1:0]         ula_b,
  output logic [3:0]                 ula_s,
  output logic                       ula_m,
  output logic                       ula_c_in,
  input  logic [SLICE_W-1:0]         ula_f,
  input  logic                       ula_c_out,
  input  logic                       ula_overflow,
  input  logic                       ula_a_eq_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [SLICE_W*N_BYTES-1:0] rsp_f,
  output logic                       rsp_c_out,
  output logic                       rsp_overflow,
  output logic                       rsp_a_eq_b
);

  localparam int unsigned W    = SLICE_W * N_BYTES;
  localparam int unsigned IdxW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_BYTES - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [3:0]        s_q, s_d;
  logic              m_q, m_d, cin_q, cin_d;
  logic              carry_q, carry_d, eq_q, eq_d;
  logic [W-1:0]      f_q, f_d;
  logic              c_out_q, c_out_d, ovf_q, ovf_d, rsp_eq_q, rsp_eq_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    m_d       = m_q;
    cin_d     = cin_q;
    carry_d   = carry_q;
    eq_d      = eq_q;
    f_d       = f_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;
    rsp_eq_d  = rsp_eq_q;
    req_ready = 1'b0;
    ula_a     = '0;
    ula_b     = '0;
    ula_s     = '0;
    ula_m     = 1'b0;
    ula_c_in  = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          s_d     = req_s;
          m_d     = req_m;
          cin_d   = req_c_in;
          idx_d   = '0;
          eq_d    = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        ula_a    = a_q[SLICE_W*int'(idx_q) +: SLICE_W];
        ula_b    = b_q[SLICE_W*int'(idx_q) +: SLICE_W];
        ula_s    = s_q;
        ula_m    = m_q;
        // Slice 0 takes the caller's carry; later slices take the previous c_out.
        ula_c_in = (idx_q == '0) ? cin_q : carry_q;
        f_d[SLICE_W*int'(idx_q) +: SLICE_W] = ula_f;
        carry_d  = ula_c_out;
        eq_d     = eq_q & ula_a_eq_b;
        if (idx_q == LastIdx) begin
          c_out_d  = ula_c_out;
          ovf_d    = ula_overflow;
          rsp_eq_d = eq_q & ula_a_eq_b;
          state_d  = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      eq_q     <= 1'b0;
      f_q      <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      rsp_eq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      eq_q     <= eq_d;
      f_q      <= f_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      rsp_eq_q <= rsp_eq_d;
    end
  end

  assign rsp_valid    = (state_q == StDone);
  assign rsp_f        = f_q;
  assign rsp_c_out    = c_out_q;
  assign rsp_overflow = ovf_q;
  assign rsp_a_eq_b   = rsp_eq_q;

endmodule

// File: doc/ula_seq_multibyte.md
Name: ula_seq_multibyte

Overview:
Multi-cycle operation sequencer placed directly upstream of ula_8_bits. It accepts one wide operation (A, B, S, M, Cin) through a valid/ready handshake. It feeds the 8-bit ULA one byte slice per cycle, LSB first, and chains the ULA carry-out into the next slice's carry-in. It then returns the assembled wide result and flags through a valid/ready response handshake. ula_8_bits is instantiated beside it at the top level; this block only drives its inputs and samples its outputs.

Parameters:
N_BYTES, 2, number of 8-bit slices per operation; legal range 2..8. Operand and result width is 8*N_BYTES.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_a  input  8*N_BYTES  operand A
req_b  input  8*N_BYTES  operand B
req_s  input  4  ULA function select, passed unchanged to every slice
req_m  input  1  ULA mode (0 arithmetic, 1 logic), passed unchanged
req_c_in  input  1  carry-in for slice 0, in ULA carry convention
ula_a  output  8  current A slice to ula_8_bits.a
ula_b  output  8  current B slice to ula_8_bits.b
ula_s  output  4  to ula_8_bits.s
ula_m  output  1  to ula_8_bits.m
ula_c_in  output  1  to ula_8_bits.c_in
ula_f  input  8  from ula_8_bits.f
ula_c_out  input  1  from ula_8_bits.c_out
ula_overflow  input  1  from ula_8_bits.overflow
ula_a_eq_b  input  1  from ula_8_bits.a_eq_b
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_f  output  8*N_BYTES  assembled result
rsp_c_out  output  1  c_out of the last slice
rsp_overflow  output  1  overflow of the last slice (signed overflow of the wide op)
rsp_a_eq_b  output  1  AND of a_eq_b over all slices

Behaviour:
- Reset (rst=1 at a clk edge), regardless of state:
  - state goes to IDLE and slice index goes to 0.
  - rsp_valid, rsp_f, rsp_c_out, rsp_overflow and rsp_a_eq_b go to 0.
  - Operand registers are cleared.
  - Any in-flight operation is discarded; no response is ever produced for it.
- States: IDLE, EXEC, DONE.
- IDLE:
  - req_ready=1.
  - When req_valid is high, latch req_a, req_b, req_s, req_m and req_c_in; set idx=0 and eq_acc=1; go to EXEC.
- EXEC:
  - req_ready=0.
  - Combinational drive: ula_a=A[8*idx+:8], ula_b=B[8*idx+:8], ula_s/ula_m from latched values.
  - ula_c_in = latched Cin when idx=0, otherwise the carry register.
  - Each EXEC cycle captures ula_f into rsp_f[8*idx+:8], ula_c_out into the carry register, and eq_acc &= ula_a_eq_b.
  - idx=N_BYTES-1: also capture rsp_c_out=ula_c_out and rsp_overflow=ula_overflow, set rsp_valid=1, go to DONE.
  - Otherwise idx increments.
- DONE:
  - rsp_valid=1, req_ready=0; all rsp_* outputs are held stable.
  - On rsp_ready=1: rsp_valid=0 next cycle, go to IDLE.
- Outside EXEC, ula_a, ula_b, ula_s, ula_m and ula_c_in are driven to 0.
- Latency: request accepted at edge k, rsp_valid high after edge k+N_BYTES.
- Throughput: one operation per N_BYTES+2 cycles at most. No request is accepted in the same cycle a response handshakes.
- The carry chain is applied identically in logic mode (m=1). The ULA ignores it there, so the result is a pure bitwise operation.
- The block performs no arithmetic of its own. Carry and overflow semantics are exactly those of ula_8_bits cascaded.
- rsp_ready asserted while rsp_valid=0 has no effect. req_valid deasserting while not ready has no effect.

Decomposition:
- Package ula_seq_pkg:
  - state enum (IDLE, EXEC, DONE);
  - localparam SLICE_W=8;
  - S code constants SEL_ADD=4'b0101 and SEL_SUB=4'b1000, used by benches.
- No sub-module inside this block. ula_8_bits is instantiated alongside it in a top wrapper, ula_seq_top, which the bench uses.

Test Plan:
1. N_BYTES=2, s=0101, m=0, c_in=0, A=0x00FF, B=0x0001 -> rsp_f=0x0100, c_out=0, overflow=0, rsp_valid 2 cycles after accept.
2. s=0101, m=0, A=0x7FFF, B=0x0001 -> rsp_f=0x8000, overflow=1, c_out=0. Then A=0xFFFF, B=0x0001 -> rsp_f=0x0000, c_out=1, overflow=0.
3. s=1000, m=0: A=B=0x5555 -> rsp_a_eq_b=1. A=0x5555, B=0xD555 (low slice equal, high differs) -> rsp_a_eq_b=0.
4. Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_* stable and req_ready=0 throughout. The next request is accepted only from IDLE, after the handshake.
5. Reset mid-op: assert rst during EXEC idx=0 -> next cycle state IDLE, rsp_valid=0, rsp_f=0, req_ready=1, and no response appears.
6. N_BYTES=4, s=0101, A=0x00FFFFFF, B=0x00000001 -> rsp_f=0x01000000. Carry ripples through 3 slices; latency 4 cycles.
